// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Write-mode encodings and pending-write entry layout for the
//            Kalman datapath bus router.
// Revision : 1.0  initial release
// ============================================================================
package router_pkg;

    localparam int DEF_W     = 24;
    localparam int DEF_ADDRW = 5;

    typedef logic [1:0] wr_mode_t;

    localparam wr_mode_t WR_PASS   = 2'd0;
    localparam wr_mode_t WR_QUEUED = 2'd1;
    localparam wr_mode_t WR_OFF    = 2'd2;
    localparam wr_mode_t WR_FORCE  = 2'd3;

    // Entry layout at default widths; instances with other widths declare
    // the same {data, addr} ordering locally.
    typedef struct packed {
        logic [DEF_W-1:0]     data;
        logic [DEF_ADDRW-1:0] addr;
    } wr_entry_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo
// Brief    : Synchronous pending-write FIFO; push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module router_fifo #(
    parameter int W_ENTRY = 29,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [W_ENTRY-1:0] i_din,
    output logic [W_ENTRY-1:0] o_dout,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTRW = $clog2(DEPTH);

    logic [W_ENTRY-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]    r_wr_ptr;
    logic [PTRW-1:0]    r_rd_ptr;
    logic [PTRW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTRW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule : router_fifo
`default_nettype wire

// File: rtl/bus_router_q.sv
`default_nettype none
// ============================================================================
// Module   : bus_router_q
// Brief    : Registered data/address bus router with pass, queued, off and
//            force write modes plus an external-address burst counter.
// Revision : 1.0  initial release
// ============================================================================
module bus_router_q
    import router_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ADDRW = DEF_ADDRW,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NSRC*W-1:0]        SRC_DATA,
    input  logic [ADDRW-1:0]         CTL_A,
    input  logic [ADDRW-1:0]         CTL_B,
    input  logic [ADDRW-1:0]         DIR_EXT,
    input  logic                     WRITE_REQ,
    input  logic                     READY,
    input  logic [$clog2(NSRC)-1:0]  sel_data,
    input  logic                     sel_zero,
    input  logic                     sel_dira,
    input  logic                     sel_dirb,
    input  logic [1:0]               sel_write,
    input  logic                     burst_start,
    input  logic [ADDRW-1:0]         burst_len,
    output logic [W-1:0]             db_data,
    output logic [ADDRW-1:0]         db_dira,
    output logic [ADDRW-1:0]         db_dirb,
    output logic                     db_write,
    output logic                     burst_busy,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     overflow
);

    localparam int SELW    = $clog2(NSRC);
    localparam int NSLOT   = 1 << SELW;
    localparam int W_ENTRY = W + ADDRW;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [ADDRW-1:0] addr;
    } entry_t;

    logic [W-1:0]     w_src [NSLOT];
    logic [ADDRW-1:0] w_ext;
    logic [W-1:0]     w_live_data;
    logic [ADDRW-1:0] w_live_a;
    logic [ADDRW-1:0] w_live_b;
    entry_t           w_push_entry;
    entry_t           w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_is_queued;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_accepted;
    logic [W-1:0]     w_nxt_data;
    logic [ADDRW-1:0] w_nxt_a;
    logic [ADDRW-1:0] w_nxt_b;
    logic             w_nxt_write;

    logic [W-1:0]     r_db_data;
    logic [ADDRW-1:0] r_db_dira;
    logic [ADDRW-1:0] r_db_dirb;
    logic             r_db_write;
    logic             r_overflow;
    logic             r_burst_busy;
    logic [ADDRW-1:0] r_burst_addr;
    logic [ADDRW-1:0] r_remaining;

    // Unused select codes (NSRC not a power of two) read as zero.
    generate
        for (genvar k = 0; k < NSLOT; k++) begin : g_src
            if (k < NSRC) begin : g_used
                assign w_src[k] = SRC_DATA[k*W +: W];
            end else begin : g_pad
                assign w_src[k] = '0;
            end
        end
    endgenerate

    assign w_ext       = r_burst_busy ? r_burst_addr : DIR_EXT;
    assign w_live_data = sel_zero ? '0 : w_src[sel_data];
    assign w_live_a    = sel_dira ? w_ext : CTL_A;
    assign w_live_b    = sel_dirb ? w_ext : CTL_B;

    assign w_push_entry = '{data: w_live_data, addr: w_live_a};

    assign w_is_queued = (sel_write == WR_QUEUED);
    assign w_pop       = w_is_queued && READY && !w_fifo_empty;
    assign w_push      = w_is_queued && WRITE_REQ && (!w_fifo_full || w_pop);
    assign w_drop      = w_is_queued && WRITE_REQ && w_fifo_full && !w_pop;

    router_fifo #(
        .W_ENTRY (W_ENTRY),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_entry),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_nxt_data  = w_live_data;
        w_nxt_a     = w_live_a;
        w_nxt_b     = w_live_b;
        w_nxt_write = 1'b0;
        w_accepted  = 1'b0;
        case (sel_write)
            WR_PASS: begin
                w_nxt_write = WRITE_REQ;
                w_accepted  = WRITE_REQ;
            end
            WR_QUEUED: begin
                w_accepted = w_push;
                if (w_pop) begin
                    w_nxt_data  = w_head.data;
                    w_nxt_a     = w_head.addr;
                    w_nxt_write = 1'b1;
                end
            end
            WR_FORCE: begin
                w_nxt_write = 1'b1;
                w_accepted  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_db_data  <= '0;
            r_db_dira  <= '0;
            r_db_dirb  <= '0;
            r_db_write <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_db_data  <= w_nxt_data;
            r_db_dira  <= w_nxt_a;
            r_db_dirb  <= w_nxt_b;
            r_db_write <= w_nxt_write;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // A restart takes precedence over advancing on the same cycle's write.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_burst_busy <= 1'b0;
            r_burst_addr <= '0;
            r_remaining  <= '0;
        end else if (burst_start) begin
            r_burst_busy <= (burst_len != '0);
            r_burst_addr <= DIR_EXT;
            r_remaining  <= burst_len;
        end else if (r_burst_busy && w_accepted) begin
            r_burst_addr <= r_burst_addr + 1'b1;
            r_remaining  <= r_remaining - 1'b1;
            if (r_remaining == ADDRW'(1)) r_burst_busy <= 1'b0;
        end
    end

    assign db_data    = r_db_data;
    assign db_dira    = r_db_dira;
    assign db_dirb    = r_db_dirb;
    assign db_write   = r_db_write;
    assign burst_busy = r_burst_busy;
    assign fifo_empty = w_fifo_empty;
    assign fifo_full  = w_fifo_full;
    assign overflow   = r_overflow;

endmodule : bus_router_q
`default_nettype wire
